// File: rtl/imm_gen_if.sv
// Handshake bundle between the IF/ID side and the ID/EX side of the immediate stage.
// The master drives instructions in and accepts results; the slave is the stage itself.
interface imm_gen_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_target;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_target, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate generation stage: decodes format and immediate from the raw instruction,
// precomputes pc + imm, and registers the result behind a 2-entry skid buffer.
module imm_gen_stage #(
  parameter int XLEN   = 32,
  parameter bit RV64_W = 1'b1
) (
  input logic        clk,
  input logic        rst,
  input logic        flush,
  imm_gen_if.slave   bus
);

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  localparam bit HAS_W = (XLEN == 64) && RV64_W;

  function automatic fmt_e decode_fmt(input logic [31:0] instr);
    fmt_e f;
    f = FMT_NONE;
    case (instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: f = FMT_I;
      7'b1110011: f = instr[14] ? FMT_Z : FMT_I;
      7'b0100011: f = FMT_S;
      7'b1100011: f = FMT_B;
      7'b0110111, 7'b0010111: f = FMT_U;
      7'b1101111: f = FMT_J;
      7'b0110011: f = FMT_R;
      7'b0011011: f = HAS_W ? FMT_I : FMT_NONE;
      7'b0111011: f = HAS_W ? FMT_R : FMT_NONE;
      default:    f = FMT_NONE;
    endcase
    return f;
  endfunction

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic signed [31:0] s;
    s = v;
    return XLEN'(s);
  endfunction

  function automatic logic [XLEN-1:0] build_imm(input logic [31:0] i, input fmt_e f);
    logic [XLEN-1:0] r;
    r = '0;
    case (f)
      FMT_I:   r = sext32({{20{i[31]}}, i[31:20]});
      FMT_S:   r = sext32({{20{i[31]}}, i[31:25], i[11:7]});
      FMT_B:   r = sext32({{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0});
      FMT_U:   r = sext32({i[31:12], 12'b0});
      FMT_J:   r = sext32({{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0});
      FMT_Z:   r = XLEN'({27'd0, i[19:15]});
      default: r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: combinational decode of the incoming instruction
  entry_t dec_p0;
  fmt_e   fmt_p0;

  always_comb begin
    fmt_p0         = decode_fmt(bus.in_instr);
    dec_p0.instr   = bus.in_instr;
    dec_p0.pc      = bus.in_pc;
    dec_p0.imm     = build_imm(bus.in_instr, fmt_p0);
    dec_p0.target  = bus.in_pc + dec_p0.imm;
    dec_p0.fmt     = fmt_p0;
    dec_p0.illegal = (fmt_p0 == FMT_NONE);
  end

  // Stage p1: OUT entry plus SKID entry
  entry_t out_p1, out_n;
  entry_t skid_p1, skid_n;
  logic   vld_p1, vld_n;
  logic   skid_vld_p1, skid_vld_n;
  logic   rdy_p1, rdy_n;
  logic   accept;

  always_comb begin
    out_n      = out_p1;
    skid_n     = skid_p1;
    vld_n      = vld_p1;
    skid_vld_n = skid_vld_p1;
    accept     = bus.in_valid & rdy_p1;
    if (flush) begin
      vld_n      = 1'b0;
      skid_vld_n = 1'b0;
    end else if (skid_vld_p1) begin
      // in_ready is low here, so no upstream accept can collide with the drain
      if (bus.out_ready) begin
        out_n      = skid_p1;
        skid_vld_n = 1'b0;
      end
    end else if (accept) begin
      if (!vld_p1 || bus.out_ready) begin
        out_n = dec_p0;
        vld_n = 1'b1;
      end else begin
        skid_n     = dec_p0;
        skid_vld_n = 1'b1;
      end
    end else if (bus.out_ready) begin
      vld_n = 1'b0;
    end
    rdy_n = ~skid_vld_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
      out_p1      <= '0;
    end else begin
      vld_p1      <= vld_n;
      skid_vld_p1 <= skid_vld_n;
      rdy_p1      <= rdy_n;
      out_p1      <= out_n;
    end
  end

  // SKID contents are only observed once skid_vld_p1 is set, so they need no reset
  always_ff @(posedge clk) begin
    skid_p1 <= skid_n;
  end

  assign bus.in_ready    = rdy_p1;
  assign bus.out_valid   = vld_p1;
  assign bus.out_instr   = out_p1.instr;
  assign bus.out_pc      = out_p1.pc;
  assign bus.out_imm     = out_p1.imm;
  assign bus.out_target  = out_p1.target;
  assign bus.out_fmt     = out_p1.fmt;
  assign bus.out_illegal = out_p1.illegal;

endmodule
